// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler draining four ingress FIFOs into one egress FIFO.
// Each grant pops at most MAX_BURST words, and egress pause/full stall scheduling.
module fifo_rr_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             fifo_empty_in,
  input  logic [4*DATA_SIZE-1:0] data_in,
  input  logic                   out_pause,
  input  logic                   out_full,
  output logic [3:0]             pop,
  output logic                   push,
  output logic [DATA_SIZE-1:0]   data_out,
  output logic [1:0]             grant_idx,
  output logic [1:0]             arb_state,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] burst_q, burst_d;
  logic       push_q;
  logic [1:0] sel_q;

  logic       stall;
  logic       can_pop;
  logic       found;
  logic [1:0] next_idx;
  logic [1:0] cand;

  assign stall   = out_pause | out_full;
  assign can_pop = (state_q == GRANT) && !fifo_empty_in[grant_q] && !stall;
  assign pop     = can_pop ? (4'b0001 << grant_q) : 4'b0000;

  // Search grant+1, +2, +3, then grant itself; walking backwards lets the
  // nearest non-empty candidate overwrite the farther ones.
  always_comb begin
    found    = 1'b0;
    next_idx = grant_q;
    cand     = grant_q;
    for (int k = 4; k >= 1; k--) begin
      cand = grant_q + 2'(k);
      if (!fifo_empty_in[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (found && !stall) begin
          state_d = GRANT;
          grant_d = next_idx;
          burst_d = 4'd0;
        end
      end
      GRANT: begin
        if (stall) begin
          state_d = HOLD;
        end else if ((can_pop && burst_q == BurstLast) || fifo_empty_in[grant_q]) begin
          burst_d = 4'd0;
          if (found) grant_d = next_idx;
          else       state_d = IDLE;
        end else if (can_pop) begin
          burst_d = burst_q + 4'd1;
        end
      end
      HOLD: begin
        if (!stall) state_d = GRANT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 2'd3;
      burst_q <= 4'd0;
      push_q  <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      push_q  <= |pop;
      sel_q   <= grant_q;
    end
  end

  // The ingress FIFO presents the popped word one cycle after the pop edge.
  assign push      = push_q;
  assign data_out  = push_q ? data_in[sel_q*DATA_SIZE +: DATA_SIZE] : '0;
  assign grant_idx = grant_q;
  assign arb_state = state_q;
  assign busy      = (state_q != IDLE) | push_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: ingress FIFOs modelled as queues,
// scheduling predicted by a cycle-level reference model of the arbitration rules.
module tb_fifo_rr_arbiter;

  localparam int DS = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    fifo_empty_in;
  logic [4*DS-1:0] data_in;
  logic          out_pause;
  logic          out_full;
  logic [3:0]    pop;
  logic          push;
  logic [DS-1:0] data_out;
  logic [1:0]    grant_idx;
  logic [1:0]    arb_state;
  logic          busy;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.DATA_SIZE(DS), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .fifo_empty_in(fifo_empty_in), .data_in(data_in),
    .out_pause(out_pause), .out_full(out_full), .pop(pop), .push(push),
    .data_out(data_out), .grant_idx(grant_idx), .arb_state(arb_state), .busy(busy)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] chq [4][$];
  logic [7:0] popReg [4];
  logic [7:0] egressLog [$];
  int runCh [$];
  int runLen [$];
  int lastRunCh;

  int mState, mGrant, mBurst;
  bit mPushPend;
  logic [7:0] mPushWord;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rrSearch(input int c);
    for (int k = 1; k <= 4; k++) begin
      if (chq[(c + k) % 4].size() != 0) return (c + k) % 4;
    end
    return -1;
  endfunction

  task automatic resetModel();
    mState = 0; mGrant = 3; mBurst = 0; mPushPend = 0; mPushWord = 8'h00;
  endtask

  task automatic load(input int ch, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) chq[ch].push_back(base + 8'(i));
  endtask

  task automatic clearLogs();
    egressLog.delete(); runCh.delete(); runLen.delete(); lastRunCh = -1;
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic step(input bit pauseIn, input bit fullIn);
    bit stall;
    int ch, nState, nGrant, nBurst, r, dutCh;
    logic [3:0] expPop;
    logic [7:0] nWord;
    out_pause = pauseIn;
    out_full  = fullIn;
    for (int i = 0; i < 4; i++) begin
      fifo_empty_in[i] = (chq[i].size() == 0);
      data_in[i*DS +: DS] = popReg[i];
    end
    #1;
    stall = pauseIn | fullIn;
    ch = (mState == 1 && chq[mGrant].size() != 0 && !stall) ? mGrant : -1;
    expPop = (ch >= 0) ? 4'(1 << ch) : 4'b0000;
    check("pop", 32'(pop), 32'(expPop));
    check("push", 32'(push), 32'(mPushPend));
    check("data_out", 32'(data_out), mPushPend ? 32'(mPushWord) : 32'h0);
    check("grant_idx", 32'(grant_idx), 32'(mGrant));
    check("arb_state", 32'(arb_state), 32'(mState));
    check("busy", 32'((mState != 0) || mPushPend), 32'(busy));
    if (push === 1'b1) egressLog.push_back(data_out);
    dutCh = -1;
    for (int i = 0; i < 4; i++) if (pop[i] === 1'b1) dutCh = i;
    if (dutCh >= 0) begin
      if (dutCh == lastRunCh) runLen[runLen.size()-1]++;
      else begin runCh.push_back(dutCh); runLen.push_back(1); end
      lastRunCh = dutCh;
    end
    nState = mState; nGrant = mGrant; nBurst = mBurst;
    case (mState)
      0: begin
        r = rrSearch(mGrant);
        if (r >= 0 && !stall) begin nState = 1; nGrant = r; nBurst = 0; end
      end
      1: begin
        if (stall) nState = 2;
        else if ((ch >= 0 && mBurst == MB - 1) || chq[mGrant].size() == 0) begin
          r = rrSearch(mGrant);
          nBurst = 0;
          if (r >= 0) nGrant = r; else nState = 0;
        end else if (ch >= 0) nBurst = mBurst + 1;
      end
      default: if (!stall) nState = 1;
    endcase
    nWord = (ch >= 0) ? chq[ch][0] : 8'h00;
    @(posedge clk);
    if (ch >= 0) popReg[ch] = chq[ch].pop_front();
    mPushPend = (ch >= 0);
    mPushWord = nWord;
    mState = nState; mGrant = nGrant; mBurst = nBurst;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int expCh [8];
    int expLen [8];
    reset = 1'b0; out_pause = 1'b0; out_full = 1'b0;
    fifo_empty_in = 4'hF; data_in = '0;
    for (int i = 0; i < 4; i++) popReg[i] = 8'h00;
    resetModel();
    clearLogs();
    @(negedge clk); @(negedge clk); #1;
    check("rst_state", 32'(arb_state), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd3);
    check("rst_push", 32'(push), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // All four channels with six words: 4-word bursts then 2-word bursts.
    clearLogs();
    for (int c = 0; c < 4; c++) load(c, 6, 8'(c * 16));
    run(40);
    expCh  = '{0, 1, 2, 3, 0, 1, 2, 3};
    expLen = '{4, 4, 4, 4, 2, 2, 2, 2};
    check("s2_runs", 32'(runCh.size()), 32'd8);
    for (int i = 0; i < 8 && i < runCh.size(); i++) begin
      check("s2_grant_order", 32'(runCh[i]), 32'(expCh[i]));
      check("s2_burst_len", 32'(runLen[i]), 32'(expLen[i]));
    end
    check("s2_push_total", 32'(egressLog.size()), 32'd24);

    // Egress full while every channel holds data: nothing moves.
    clearLogs();
    for (int c = 0; c < 4; c++) load(c, 3, 8'h40 + 8'(c * 8));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("full_idle", 32'(arb_state), 32'd0);
    run(25);
    check("full_first_grant", 32'(runCh.size() > 0 ? runCh[0] : -1), 32'd0);

    // Only channel 2 with three words.
    clearLogs();
    load(2, 3, 8'hA1);
    run(8);
    check("s1_count", 32'(egressLog.size()), 32'd3);
    for (int i = 0; i < 3 && i < egressLog.size(); i++)
      check("s1_word", 32'(egressLog[i]), 32'hA1 + 32'(i));
    check("s1_grant", 32'(grant_idx), 32'd2);
    check("s1_idle", 32'(arb_state), 32'd0);

    // Pause mid-burst on channel 1 after two pops.
    clearLogs();
    load(1, 8, 8'h10);
    run(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("pause_hold", 32'(arb_state), 32'd2);
    check("pause_pushes", 32'(egressLog.size()), 32'd2);
    run(15);
    check("pause_total", 32'(egressLog.size()), 32'd8);

    // Channel 0 one word, channel 1 two words.
    clearLogs();
    load(0, 1, 8'hC0);
    load(1, 2, 8'hD0);
    run(10);
    check("s6_count", 32'(egressLog.size()), 32'd3);
    if (egressLog.size() == 3) begin
      check("s6_w0", 32'(egressLog[0]), 32'hC0);
      check("s6_w1", 32'(egressLog[1]), 32'hD0);
      check("s6_w2", 32'(egressLog[2]), 32'hD1);
    end

    // Reset right after a pop from channel 3; that word is lost.
    clearLogs();
    load(3, 4, 8'hE0);
    run(2);
    reset = 1'b0;
    #1;
    check("mid_rst_push", 32'(push), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_pop", 32'(pop), 32'd0);
    check("mid_rst_state", 32'(arb_state), 32'd0);
    check("mid_rst_grant", 32'(grant_idx), 32'd3);
    check("mid_rst_busy", 32'(busy), 32'd0);
    resetModel();
    load(0, 2, 8'hF0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0);
    check("post_rst_grant", 32'(grant_idx), 32'd0);
    run(20);

    // Randomized traffic with occasional back-pressure.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 45) chq[$urandom_range(0, 3)].push_back(8'($urandom));
      step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
    end
    run(80);
    check("drained", 32'(chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin scheduler that drains four 8-bit ingress FIFOs (virtual channels) into one egress FIFO of the PCIe switching datapath. It issues read strobes to the ingress FIFOs and a write strobe to the egress FIFO. Egress back-pressure (pause/full) gates scheduling. A per-grant burst limit keeps the channels fair.

## Interface
- DATA_SIZE, 8, word width of every FIFO
- MAX_BURST, 4, max consecutive pops from one channel per grant (1..15)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- fifo_empty_in  in  4  fifo_empty of ingress FIFO i (bit i)
- data_in  in  4*DATA_SIZE  data_out_pop of ingress FIFO i at bits [i*DATA_SIZE +: DATA_SIZE]
- out_pause  in  1  egress FIFO fifo_pause (almost full)
- out_full  in  1  egress FIFO Fifo_full
- pop  out  4  read strobe to ingress FIFO i, one-hot or zero
- push  out  1  write strobe to egress FIFO
- data_out  out  DATA_SIZE  word to egress data_in_push; valid only while push=1
- grant_idx  out  2  currently granted channel
- arb_state  out  2  FSM state: 0 IDLE, 1 GRANT, 2 HOLD
- busy  out  1  1 when arb_state != IDLE or push=1

## Operation
- Registered state: arb_state, grant_idx, burst_cnt (4 bits), push_d, sel_d (2 bits).
- pop[i] is combinational: `arb_state==GRANT & grant_idx==i & ~fifo_empty_in[i] & ~out_pause & ~out_full`. The block never pops an empty FIFO and never pops while the egress is paused or full.
- Round-robin search from channel c: check (c+1)%4, (c+2)%4, (c+3)%4, then c itself. The first channel with fifo_empty_in=0 wins.
- IDLE:
  - If any channel is non-empty and out_pause=0 and out_full=0: go to GRANT.
  - grant_idx = search result from grant_idx; burst_cnt = 0.
- GRANT, at each edge:
  - If out_pause|out_full: go to HOLD. Keep grant_idx and burst_cnt.
  - Else if a pop happened and burst_cnt==MAX_BURST-1: rotate.
  - Else if fifo_empty_in[grant_idx]=1: rotate.
  - Else if a pop happened: burst_cnt+1.
- Rotate:
  - Search from grant_idx and reload burst_cnt=0.
  - The evaluation uses current-cycle empty flags. A channel that just issued its last pop may still show non-empty. It is then re-granted and goes empty one cycle later, costing one bubble with no error.
  - If no channel is non-empty: go to IDLE and keep grant_idx as the last grant.
- HOLD: return to GRANT when out_pause=0 and out_full=0. Same grant_idx, burst_cnt unchanged.
- Datapath, per edge: push_d <= |pop and sel_d <= grant_idx.
  - push = push_d.
  - data_out = push_d ? data_in[sel_d] : 0.
- The in-flight word is always pushed, even if pause asserted in the meantime. The egress FIFO pause threshold leaves room for it.

## Timing
- Reset values: arb_state=IDLE, grant_idx=3 (so the first search starts at channel 0), burst_cnt=0, push=0, pop=0, data_out=0, busy=0.
- Reset mid-transfer: a pending push is dropped and the FSM goes to IDLE asynchronously.
- Latency:
  - IDLE→GRANT takes 1 edge after a request appears.
  - The first pop comes in the GRANT cycle.
  - The ingress FIFO registers the word on the pop edge.
  - push and data_out are asserted the cycle after the pop, for 1 cycle.
- Throughput:
  - 1 word/cycle within a burst.
  - At most one bubble cycle per rotation when the current channel empties.
  - No bubble when the burst limit triggers rotation to another non-empty channel.
- Simultaneous events:
  - Pause has priority over rotation.
  - A burst-limit hit takes priority over empty.
  - pop and push may both be active in the same cycle for different words.

## Test plan
- Reset, then only channel 2 holds 3 words (0xA1, 0xA2, 0xA3), egress empty.
  - Required: pop[2] on 3 consecutive cycles, then push with 0xA1, 0xA2, 0xA3 one cycle later each.
  - Required: return to IDLE with grant_idx=2.
- All 4 channels hold 6 words, MAX_BURST=4, egress never pauses.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: 4 pops per first grant, 2 per second grant, total 24 pushes, no bubbles inside a burst.
- Channel 1 streaming; force out_pause=1 for 5 cycles mid-burst after 2 pops.
  - Required: pop=0 during the pause, exactly 1 trailing push, arb_state=HOLD.
  - Required: resume on channel 1 with 2 pops left in the burst.
- out_full=1 while every channel is non-empty.
  - Required: zero pops and arb_state stays IDLE.
  - Release full: required first grant goes to channel 0.
- Assert reset low for 1 cycle in the cycle right after a pop from channel 3.
  - Required: push stays 0, the word is lost, all outputs return to reset values.
  - Required: the next grant after reset goes to channel 0.
- Channel 0 holds exactly 1 word and channel 1 holds 2 words.
  - Required: one pop[0], then at most 1 bubble, then two pop[1].
  - Required: 3 pushes in order 0,1,1, with no pop of an empty FIFO.
